// File: rtl/lfsr_collector_pkg.sv
// ============================================================================
// Module   : lfsr_collector_pkg
// Purpose  : Shared types, default sizes and word-parity helper for the
//            LFSR word collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_collector_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int c_default_width = 4;
  localparam int c_default_depth = 4;

  // Callers zero-extend their word; leading zeros do not change the XOR.
  function automatic logic word_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_collector_fifo.sv
// ============================================================================
// Module   : lfsr_collector_fifo
// Purpose  : DEPTH-entry synchronous FIFO; pointers carry one extra wrap bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_collector_fifo
  import lfsr_collector_pkg::*;
#(
  parameter int ENTRY_W = c_default_width,
  parameter int DEPTH   = c_default_depth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [ENTRY_W-1:0]       i_data,
  output logic [ENTRY_W-1:0]       o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]        r_wr_ptr;
  logic [c_aw:0]        r_rd_ptr;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign o_fill  = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[c_aw-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_word_collector.sv
// ============================================================================
// Module   : lfsr_word_collector
// Purpose  : Packs the LFSR serial stream LSB-first into WIDTH-bit words and
//            buffers them for a valid/ready consumer. Defining
//            LFSR_COLLECTOR_PARITY_EN adds a per-word parity output word_par.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_word_collector
  import lfsr_collector_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int DEPTH = c_default_depth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overflow,
`ifdef LFSR_COLLECTOR_PARITY_EN
  output logic                     word_par,
`endif
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
`ifdef LFSR_COLLECTOR_PARITY_EN
  localparam int c_entry_w = WIDTH + 1;
`else
  localparam int c_entry_w = WIDTH;
`endif

  state_t               r_state;
  state_t               w_state_next;
  logic [c_cnt_w-1:0]   r_bit_cnt;
  logic [WIDTH-2:0]     r_shift;
  logic                 r_overflow;
  logic                 w_complete;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [WIDTH-1:0]     w_word;
  logic [c_entry_w-1:0] w_entry;
  logic [c_entry_w-1:0] w_head;

  assign w_complete = ser_valid && (r_bit_cnt == c_last_bit);
  assign w_word     = {ser_in, r_shift};
  assign w_pop      = !w_empty && word_ready;
  assign w_drop     = w_complete && w_full && !w_pop;

`ifdef LFSR_COLLECTOR_PARITY_EN
  assign w_entry  = {word_parity(64'(w_word)), w_word};
  assign word_out = w_head[WIDTH-1:0];
  assign word_par = w_head[WIDTH];
`else
  assign w_entry  = w_word;
  assign word_out = w_head;
`endif

  assign word_valid = !w_empty;
  assign overflow   = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (ser_valid)  w_state_next = COLLECT;
      COLLECT: if (w_complete) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bit k of the word lands in shift[k]; the final bit goes straight to the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_complete) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (ser_valid) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      for (int k = 0; k < WIDTH - 1; k++) begin
        if (r_bit_cnt == c_cnt_w'(k)) begin
          r_shift[k] <= ser_in;
        end
      end
    end
  end

  // A fresh drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  lfsr_collector_fifo #(
    .ENTRY_W (c_entry_w),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_complete),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (fill)
  );

endmodule

`default_nettype wire

// File: tb/tb_lfsr_word_collector.sv
// ============================================================================
// Module   : tb_lfsr_word_collector
// Purpose  : Self-checking bench for lfsr_word_collector (WIDTH=4, DEPTH=4);
//            also checks word_par when LFSR_COLLECTOR_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_word_collector;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic         overflow;
  logic [2:0]   fill;
`ifdef LFSR_COLLECTOR_PARITY_EN
  logic         word_par;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of whole words plus the partial word being built.
  logic [W-1:0] q[$];
  logic [W-1:0] part;
  int           nbits;
  bit           m_ovf;

  lfsr_word_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .clr_ovf    (clr_ovf),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
`ifdef LFSR_COLLECTOR_PARITY_EN
    .word_par   (word_par),
`endif
    .fill       (fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    part  = '0;
    nbits = 0;
    m_ovf = 1'b0;
  endtask

  task automatic compare_model();
    check("word_valid", word_valid, q.size() != 0);
    check("fill", fill, q.size());
    check("overflow", overflow, m_ovf);
    if (q.size() != 0) begin
      check("word_out", word_out, q[0]);
`ifdef LFSR_COLLECTOR_PARITY_EN
      check("word_par", word_par, ^q[0]);
`endif
    end
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, compare.
  task automatic step(input bit sv, input bit sin, input bit rdy, input bit clr);
    int           pre;
    bit           pop;
    bit           drop;
    logic [W-1:0] w;
    ser_valid  = sv;
    ser_in     = sin;
    word_ready = rdy;
    clr_ovf    = clr;
    @(posedge clk);
    pre  = q.size();
    pop  = (pre != 0) && rdy;
    drop = 1'b0;
    if (pop) void'(q.pop_front());
    if (sv && nbits == W - 1) begin
      w = part | (W'(sin) << (W - 1));
      if (pre < D || pop) q.push_back(w);
      else begin
        m_ovf = 1'b1;
        drop  = 1'b1;
      end
      part  = '0;
      nbits = 0;
    end else if (sv) begin
      part  = part | (W'(sin) << nbits);
      nbits = nbits + 1;
    end
    if (clr && !drop) m_ovf = 1'b0;
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit last_rdy);
    for (int b = 0; b < W; b++) begin
      step(1'b1, w[b], (b == W - 1) ? last_rdy : 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ser_valid = 1'b0;
    word_ready = 1'b0;
    clr_ovf = 1'b0;
    #1;
    model_clear();
    compare_model();
    check("reset word_out", word_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           sv;
    bit           sin;
    bit           rdy;
    bit           clr;
    logic [W-1:0] word;
    bit           valid;
    int           fill;
    bit           ovf;
  } vec_t;

  vec_t         tbl[11];
  logic [W-1:0] words[5];

  initial begin
    // Bits 1,0,0,1 -> 4'b1001; pop it; then 1,1, gap of 3, 0,1 -> 4'b1011.
    tbl[0]  = '{1, 1, 0, 0, 4'h0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 4'h0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 4'h0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 4'b1001, 1, 1, 0};
    tbl[4]  = '{1, 1, 1, 0, 4'h0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 4'h0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 4'h0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 4'h0, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 4'h0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 4'h0, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 4'b1011, 1, 1, 0};

    model_clear();
    #12;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].sv, tbl[i].sin, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d valid", i), word_valid, tbl[i].valid);
      check($sformatf("tbl%0d fill", i), fill, tbl[i].fill);
      check($sformatf("tbl%0d ovf", i), overflow, tbl[i].ovf);
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d word", i), word_out, tbl[i].word);
`ifdef LFSR_COLLECTOR_PARITY_EN
        check($sformatf("tbl%0d par", i), word_par, (i == 10) ? 1 : 0);
`endif
      end
    end

    // Overflow: five words with no consumer, drain in order, then clear.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      words[i] = W'($urandom);
      send_word(words[i], 1'b0);
    end
    check("ovf fill", fill, 4);
    check("ovf flag", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), word_out, words[i]);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("drained valid", word_valid, 0);
    check("ovf sticky", overflow, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf cleared", overflow, 0);

    // Full FIFO with a pop on the completing edge: no drop, new word at tail.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      words[i] = W'($urandom);
      send_word(words[i], i == 4);
    end
    check("full+pop fill", fill, 4);
    check("full+pop ovf", overflow, 0);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("full+pop drain%0d", i), word_out, words[i]);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-word with two buffered words.
    do_reset();
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre-rst fill", fill, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", word_valid, 0);
    check("async rst fill", fill, 0);
    check("async rst word", word_out, 0);
    check("async rst ovf", overflow, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(4'b0110, 1'b0);
    check("post-rst word", word_out, 4'b0110);
    check("post-rst fill", fill, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
